enet_mii_to_rmii_tx: RTL and testbench
======================================

Name: enet_mii_to_rmii_tx

Overview:
Transmit-direction MII-to-RMII bridge that sits between the MAC's MII transmit port and the RMII PHY. It generates mii_tx_clk from the 50 MHz rmii_ref_clk: 25 MHz in 100M mode, 2.5 MHz in 10M mode. It samples each MII nibble and serialises it onto RMII as two dibits, low dibit first. It is the transmit companion of enet_rmii_to_mii_rx and uses the same clocking scheme and mode input.

Parameters:
DIV_10T, 10, rmii_ref_clk cycles per mii_tx_clk half-period in 10M mode; equals cycles each dibit is held.
CNT_W, 4, width of the divider counter; must satisfy 2^CNT_W > DIV_10T-1.

Ports:
rmii_ref_clk  in  1  RMII 50 MHz reference clock; the only clock.
rst_ref_n  in  1  Reset, asynchronous, active-low.
rmii_10T  in  1  1 = 10M mode, 0 = 100M mode; quasi-static.
mii_tx_clk  out  1  Generated MII transmit clock to the MAC (register output).
mii_tx_en  in  1  MII transmit enable; MAC launches it on mii_tx_clk rise.
mii_tx_er  in  1  MII transmit error.
mii_txd  in  4  MII transmit nibble.
rmii_tx_en  out  1  RMII transmit enable (register output).
rmii_txd  out  2  RMII transmit dibit (register output).
tx_er_pulse  out  1  One-ref-cycle pulse per nibble sampled with mii_tx_en=1 and mii_tx_er=1.
tx_busy  out  1  1 while rmii_tx_en=1 or the high dibit of the last nibble is pending.

Behaviour:
- Reset: mii_tx_clk=0, rmii_tx_en=0, rmii_txd=00, tx_er_pulse=0, tx_busy=0, cnt=0, hi_dibit=00, mode_q=0.
- Mode latch: mode_q <= rmii_10T only at a rise strobe while tx_busy=0, and cnt is then cleared. A change mid-frame has no effect until the frame ends; the dibit stream is never torn.
- Step strobe: step = !mode_q | (cnt==DIV_10T-1).
  - On step: mii_tx_clk toggles and cnt clears.
  - Otherwise, in 10M mode, cnt increments.
  - In 100M mode cnt stays 0.
- Strobe names: fall = step & mii_tx_clk (clock going 1->0); rise = step & !mii_tx_clk.
- On fall (sample point, MII inputs stable half a period after launch):
  - rmii_txd <= mii_tx_en ? mii_txd[1:0] : 00
  - hi_dibit <= mii_tx_en ? mii_txd[3:2] : 00
  - rmii_tx_en <= mii_tx_en
  - tx_er_pulse <= mii_tx_en & mii_tx_er (all other cycles 0)
- On rise: rmii_txd <= hi_dibit; rmii_tx_en holds.
- Resulting timing: each dibit is held 1 ref cycle (100M) or DIV_10T ref cycles (10M). Latency from sample edge to low dibit on RMII is 0 extra cycles (same edge); the high dibit follows one dibit-period later.
- Frame end: the first fall with mii_tx_en=0 drops rmii_tx_en and drives txd=00. tx_busy clears at the same edge.
- mii_tx_er: RMII has no TX_ER, so data passes unmodified and only tx_er_pulse is raised. mii_tx_er with mii_tx_en=0 is ignored.
- Reset asserted mid-frame: all outputs return to reset values immediately (asynchronous). After release, the frame restarts cleanly at the next fall with mii_tx_en=1.
- mii_tx_clk duty is 50% in both modes; its period is 2 or 2*DIV_10T ref cycles.

Decomposition:
- No shared package required. DIV_10T is local to this block and must match the value used by the RX bridge.
- One natural sub-module: enet_mii_clk_gen (cnt, mode_q, mii_tx_clk, rise/fall strobes), reusable by the RX side.
- Data and strobe registers are built with FF_D_with_wen.

Test Plan:
- 100M, MAC sends nibbles 0x5,0x5,0xD with tx_en=1 -> rmii_txd sequence 01,01,01,01,01,11 with rmii_tx_en=1, one dibit per ref cycle, mii_tx_clk period 2 ref cycles.
- 10M, nibble 0xA then tx_en=0 -> rmii_txd=10 for 10 cycles, then 10 for 10 cycles, then rmii_tx_en=0 with txd=00; mii_tx_clk period 20 cycles.
- mii_tx_er=1 on the third nibble of a 100M frame -> exactly one tx_er_pulse cycle at that nibble's fall edge; rmii_txd is unchanged.
- Toggle rmii_10T mid-frame -> dibit rate unchanged until rmii_tx_en falls, then mii_tx_clk switches period at the next rise strobe.
- Assert rst_ref_n low during a 10M frame -> next cycle all outputs are 0 and mii_tx_clk=0; after release, a new frame 0x5 produces 01,01 correctly aligned.
- Idle with mii_tx_en=0 and random mii_txd -> rmii_tx_en=0 and rmii_txd=00 throughout.

Source files
------------

// File: rtl/enet_mii_to_rmii_tx_pkg.sv
// Shared constants and types for the MII/RMII bridges.
package enet_mii_to_rmii_tx_pkg;

    // Ref-clock cycles per mii_tx_clk half-period in 10M mode.
    // Must match the value used by the receive-side bridge.
    localparam int DIV_10T_DEFAULT = 10;
    localparam int CNT_W_DEFAULT   = 4;

    // Dibit driven on RMII when nothing is being transmitted.
    localparam logic [1:0] DIBIT_IDLE = 2'b00;

    typedef enum logic {
        MODE_100M = 1'b0,
        MODE_10M  = 1'b1
    } mii_mode_e;

endpackage

// File: rtl/FF_D_with_wen.sv
// D flip-flop with write enable and asynchronous active-low reset.
module FF_D_with_wen #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         rmii_ref_clk,
    input  logic         rst_ref_n,
    input  logic         wen,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    // Load d when enabled; reset value applied immediately on reset.
    always_ff @(posedge rmii_ref_clk or negedge rst_ref_n) begin
        if (!rst_ref_n) begin
            q <= RST_VAL;
        end else if (wen) begin
            q <= d;
        end
    end

endmodule

// File: rtl/enet_mii_clk_gen.sv
// MII clock generator: divides the 50 MHz RMII reference down to the MII
// clock and exposes one-cycle rise/fall strobes aligned with its edges.
// The speed mode is only adopted at a rise strobe while the link is idle,
// so an in-flight frame always finishes at the rate it started with.
module enet_mii_clk_gen
    import enet_mii_to_rmii_tx_pkg::*;
#(
    parameter int DIV_10T = DIV_10T_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic rmii_ref_clk,
    input  logic rst_ref_n,
    input  logic rmii_10T,
    input  logic busy,
    output logic mii_clk,
    output logic rise,
    output logic fall
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_10T - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clk_q, clk_d;
    mii_mode_e        mode_q, mode_d;
    logic             step;

    // Divider step, edge strobes and idle-only mode adoption.
    always_comb begin
        step   = (mode_q == MODE_100M) || (cnt_q == CNT_LAST);
        rise   = step && !clk_q;
        fall   = step && clk_q;
        clk_d  = clk_q;
        cnt_d  = cnt_q;
        mode_d = mode_q;
        if (step) begin
            clk_d = !clk_q;
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(1);
        end
        if (rise && !busy) begin
            mode_d = mii_mode_e'(rmii_10T);
            cnt_d  = '0;
        end
    end

    // Divider state registers.
    always_ff @(posedge rmii_ref_clk or negedge rst_ref_n) begin
        if (!rst_ref_n) begin
            cnt_q  <= '0;
            clk_q  <= 1'b0;
            mode_q <= MODE_100M;
        end else begin
            cnt_q  <= cnt_d;
            clk_q  <= clk_d;
            mode_q <= mode_d;
        end
    end

    assign mii_clk = clk_q;

endmodule

// File: rtl/enet_mii_to_rmii_tx.sv
// Transmit MII-to-RMII bridge. Each MII nibble is sampled half an MII
// period after the MAC launches it (the fall strobe) and leaves on RMII as
// two dibits, low dibit at the sample edge and high dibit at the next rise.
module enet_mii_to_rmii_tx
    import enet_mii_to_rmii_tx_pkg::*;
#(
    parameter int DIV_10T = DIV_10T_DEFAULT,
    parameter int CNT_W   = CNT_W_DEFAULT
) (
    input  logic       rmii_ref_clk,
    input  logic       rst_ref_n,
    input  logic       rmii_10T,
    output logic       mii_tx_clk,
    input  logic       mii_tx_en,
    input  logic       mii_tx_er,
    input  logic [3:0] mii_txd,
    output logic       rmii_tx_en,
    output logic [1:0] rmii_txd,
    output logic       tx_er_pulse,
    output logic       tx_busy
);

    logic       rise, fall;
    logic [1:0] rmii_txd_q, rmii_txd_d;
    logic [1:0] hi_dibit_q, hi_dibit_d;
    logic       rmii_tx_en_q, rmii_tx_en_d;
    logic       tx_er_pulse_q, tx_er_pulse_d;
    logic       tx_busy_q, tx_busy_d;
    logic       txd_wen;

    enet_mii_clk_gen #(
        .DIV_10T (DIV_10T),
        .CNT_W   (CNT_W)
    ) u_clk_gen (
        .rmii_ref_clk (rmii_ref_clk),
        .rst_ref_n    (rst_ref_n),
        .rmii_10T     (rmii_10T),
        .busy         (tx_busy_q),
        .mii_clk      (mii_tx_clk),
        .rise         (rise),
        .fall         (fall)
    );

    // Next values: sample at fall, emit the stored high dibit at rise.
    // TX_ER has no RMII counterpart, so it only produces a status pulse.
    always_comb begin
        txd_wen       = fall || rise;
        rmii_txd_d    = rmii_txd_q;
        if (fall) begin
            rmii_txd_d = mii_tx_en ? mii_txd[1:0] : DIBIT_IDLE;
        end else if (rise) begin
            rmii_txd_d = hi_dibit_q;
        end
        hi_dibit_d    = mii_tx_en ? mii_txd[3:2] : DIBIT_IDLE;
        rmii_tx_en_d  = mii_tx_en;
        tx_busy_d     = mii_tx_en;
        tx_er_pulse_d = fall && mii_tx_en && mii_tx_er;
    end

    FF_D_with_wen #(.W(2)) u_txd_ff (
        .rmii_ref_clk (rmii_ref_clk), .rst_ref_n (rst_ref_n),
        .wen (txd_wen), .d (rmii_txd_d), .q (rmii_txd_q)
    );

    FF_D_with_wen #(.W(2)) u_hi_ff (
        .rmii_ref_clk (rmii_ref_clk), .rst_ref_n (rst_ref_n),
        .wen (fall), .d (hi_dibit_d), .q (hi_dibit_q)
    );

    FF_D_with_wen #(.W(1)) u_en_ff (
        .rmii_ref_clk (rmii_ref_clk), .rst_ref_n (rst_ref_n),
        .wen (fall), .d (rmii_tx_en_d), .q (rmii_tx_en_q)
    );

    // Busy tracks the sampled enable: the high dibit always goes out before
    // the next sample point, so nothing is pending once enable is low.
    FF_D_with_wen #(.W(1)) u_busy_ff (
        .rmii_ref_clk (rmii_ref_clk), .rst_ref_n (rst_ref_n),
        .wen (fall), .d (tx_busy_d), .q (tx_busy_q)
    );

    FF_D_with_wen #(.W(1)) u_er_ff (
        .rmii_ref_clk (rmii_ref_clk), .rst_ref_n (rst_ref_n),
        .wen (1'b1), .d (tx_er_pulse_d), .q (tx_er_pulse_q)
    );

    assign rmii_txd    = rmii_txd_q;
    assign rmii_tx_en  = rmii_tx_en_q;
    assign tx_er_pulse = tx_er_pulse_q;
    assign tx_busy     = tx_busy_q;

endmodule

// File: tb/tb_enet_mii_to_rmii_tx.sv
// Bench for the TX MII-to-RMII bridge. A MAC model launches nibbles on each
// mii_tx_clk rise; expected RMII dibit slots are queued at launch and
// compared at each MII clock edge, with hold checks in between.
module tb_enet_mii_to_rmii_tx;

    localparam int DIV = 10;

    logic       rmii_ref_clk = 1'b0;
    logic       rst_ref_n    = 1'b0;
    logic       rmii_10T     = 1'b0;
    logic       mii_tx_en    = 1'b0;
    logic       mii_tx_er    = 1'b0;
    logic [3:0] mii_txd      = 4'h0;
    logic       mii_tx_clk;
    logic       rmii_tx_en;
    logic [1:0] rmii_txd;
    logic       tx_er_pulse;
    logic       tx_busy;

    always #10 rmii_ref_clk = ~rmii_ref_clk;

    enet_mii_to_rmii_tx #(.DIV_10T(DIV), .CNT_W(4)) dut (
        .rmii_ref_clk (rmii_ref_clk),
        .rst_ref_n    (rst_ref_n),
        .rmii_10T     (rmii_10T),
        .mii_tx_clk   (mii_tx_clk),
        .mii_tx_en    (mii_tx_en),
        .mii_tx_er    (mii_tx_er),
        .mii_txd      (mii_txd),
        .rmii_tx_en   (rmii_tx_en),
        .rmii_txd     (rmii_txd),
        .tx_er_pulse  (tx_er_pulse),
        .tx_busy      (tx_busy)
    );

    typedef struct packed { logic en; logic [1:0] d; logic er; } slot_t;
    typedef struct packed { logic en; logic er; logic [3:0] d; } nib_t;

    slot_t sb_q[$];     // expected RMII slots, one per MII clock edge
    nib_t  stim_q[$];   // nibbles the MAC model will launch
    slot_t cur;         // slot currently expected on RMII
    int    cyc_since;
    int    half_exp;
    logic  clk_exp;
    logic  model_mode;
    int    vectors     = 0;
    int    miscompares = 0;

    task automatic model_reset();
        sb_q.delete();
        cur        = '0;
        cyc_since  = 0;
        half_exp   = 1;
        clk_exp    = 1'b0;
        model_mode = 1'b0;
    endtask

    // MAC launch at a rise: queue the two slots this nibble must produce.
    task automatic launch();
        nib_t n;
        if (stim_q.size() > 0) begin
            n = stim_q.pop_front();
        end else begin
            n.en = 1'b0;
            n.er = 1'($urandom);
            n.d  = 4'($urandom);
        end
        mii_tx_en = n.en;
        mii_tx_er = n.er;
        mii_txd   = n.d;
        if (n.en) begin
            sb_q.push_back({1'b1, n.d[1:0], n.er});
            sb_q.push_back({1'b1, n.d[3:2], 1'b0});
        end else begin
            sb_q.push_back('0);
            sb_q.push_back('0);
        end
    endtask

    // One ref cycle: sample #1 after the edge, check, then drive the MAC side.
    task automatic tick();
        logic trans;
        logic er_exp;
        @(posedge rmii_ref_clk);
        #1;
        if (!rst_ref_n) begin
            vectors++;
            if ({mii_tx_clk, rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy} !== 6'b0) begin
                miscompares++;
                $display("FAIL reset_hold: outputs clk/en/txd/er/busy=%b expected 000000",
                         {mii_tx_clk, rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy});
            end
            mii_tx_en = 1'b0;
            mii_tx_er = 1'b0;
            model_reset();
            return;
        end
        cyc_since++;
        trans = (cyc_since == half_exp);
        if (trans) begin
            clk_exp   = !clk_exp;
            cyc_since = 0;
        end
        vectors++;
        if (mii_tx_clk !== clk_exp) begin
            miscompares++;
            $display("FAIL mii_tx_clk: got %b expected %b (half-period %0d)", mii_tx_clk, clk_exp, half_exp);
        end
        er_exp = 1'b0;
        if (trans) begin
            cur    = (sb_q.size() > 0) ? sb_q.pop_front() : slot_t'('0);
            er_exp = cur.er;
        end
        vectors++;
        if ({rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy} !== {cur.en, cur.d, er_exp, cur.en}) begin
            miscompares++;
            $display("FAIL rmii_%s: en/txd/er/busy got %b %b %b %b expected %b %b %b %b",
                     trans ? "edge" : "hold", rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy,
                     cur.en, cur.d, er_exp, cur.en);
        end
        if (trans && clk_exp) begin
            if (!cur.en) model_mode = rmii_10T;
            half_exp = model_mode ? DIV : 1;
            launch();
        end
    endtask

    task automatic run_drain(input string name, input int budget);
        int n = 0;
        while (stim_q.size() > 0 && n < budget) begin
            tick();
            n++;
        end
        vectors++;
        if (stim_q.size() > 0) begin
            miscompares++;
            $display("FAIL %s_drain: %0d nibbles still queued after %0d cycles, expected 0",
                     name, stim_q.size(), n);
            stim_q.delete();
        end
        for (int i = 0; i < 4 * half_exp + 4; i++) tick();
    endtask

    task automatic test_reset();
        model_reset();
        rst_ref_n = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        @(negedge rmii_ref_clk);
        rst_ref_n = 1'b1;
        for (int i = 0; i < 6; i++) tick();
    endtask

    task automatic test_100m_frame();
        logic [1:0] seen[$];
        logic [1:0] want[6];
        want = '{2'b01, 2'b01, 2'b01, 2'b01, 2'b01, 2'b11};
        stim_q.push_back({1'b1, 1'b0, 4'h5});
        stim_q.push_back({1'b1, 1'b0, 4'h5});
        stim_q.push_back({1'b1, 1'b0, 4'hD});
        for (int i = 0; i < 20; i++) begin
            tick();
            if (rmii_tx_en) seen.push_back(rmii_txd);
        end
        vectors++;
        if (seen.size() != 6) begin
            miscompares++;
            $display("FAIL 100m_len: %0d dibits with tx_en, expected 6", seen.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                vectors++;
                if (seen[i] !== want[i]) begin
                    miscompares++;
                    $display("FAIL 100m_dibit%0d: got %b expected %b", i, seen[i], want[i]);
                end
            end
        end
    endtask

    task automatic test_tx_er();
        int pulses = 0;
        for (int i = 0; i < 5; i++)
            stim_q.push_back({1'b1, (i == 2), 4'(4'h3 + 4'(i * 3))});
        for (int i = 0; i < 24; i++) begin
            tick();
            if (tx_er_pulse === 1'b1) pulses++;
        end
        vectors++;
        if (pulses != 1) begin
            miscompares++;
            $display("FAIL tx_er_count: %0d pulses, expected 1", pulses);
        end
    endtask

    task automatic test_idle();
        int bad = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (rmii_tx_en !== 1'b0 || rmii_txd !== 2'b00) bad++;
        end
        vectors++;
        if (bad != 0) begin
            miscompares++;
            $display("FAIL idle: %0d cycles with activity, expected 0", bad);
        end
    endtask

    task automatic test_mode_change();
        for (int i = 0; i < 8; i++) stim_q.push_back({1'b1, 1'b0, 4'($urandom)});
        for (int i = 0; i < 4; i++) tick();
        rmii_10T = 1'b1;
        run_drain("mode_change", 200);
    endtask

    task automatic test_10m_frame();
        int cnt10 = 0;
        int n = 0;
        while (!model_mode && n < 100) begin
            tick();
            n++;
        end
        stim_q.push_back({1'b1, 1'b0, 4'hA});
        for (int i = 0; i < 120; i++) begin
            tick();
            if (rmii_tx_en === 1'b1 && rmii_txd === 2'b10) cnt10++;
        end
        vectors++;
        if (cnt10 != 2 * DIV) begin
            miscompares++;
            $display("FAIL 10m_hold: %0d cycles of dibit 10, expected %0d", cnt10, 2 * DIV);
        end
    endtask

    task automatic test_reset_midframe();
        logic [1:0] seen[$];
        for (int i = 0; i < 4; i++) stim_q.push_back({1'b1, 1'b0, 4'hF});
        for (int i = 0; i < 35; i++) tick();
        @(negedge rmii_ref_clk);
        rst_ref_n = 1'b0;
        #1;
        vectors++;
        if ({mii_tx_clk, rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy} !== 6'b0) begin
            miscompares++;
            $display("FAIL async_reset: outputs clk/en/txd/er/busy=%b expected 000000",
                     {mii_tx_clk, rmii_tx_en, rmii_txd, tx_er_pulse, tx_busy});
        end
        stim_q.delete();
        for (int i = 0; i < 3; i++) tick();
        @(negedge rmii_ref_clk);
        rst_ref_n = 1'b1;
        stim_q.push_back({1'b1, 1'b0, 4'h5});
        for (int i = 0; i < 100; i++) begin
            tick();
            if (rmii_tx_en === 1'b1) seen.push_back(rmii_txd);
        end
        vectors++;
        if (seen.size() != 2 * DIV) begin
            miscompares++;
            $display("FAIL post_reset_len: %0d dibit cycles, expected %0d", seen.size(), 2 * DIV);
        end
        for (int i = 0; i < seen.size(); i++) begin
            vectors++;
            if (seen[i] !== 2'b01) begin
                miscompares++;
                $display("FAIL post_reset_dibit%0d: got %b expected 01", i, seen[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_100m_frame();
        test_tx_er();
        test_idle();
        test_mode_change();
        test_10m_frame();
        test_reset_midframe();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
